// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// mc_ctrl_pkg : opcode/func, mux, ALU and state codes for the multi-cycle core
// Rev 1.0
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_ORI   = 6'b001101;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_BNE   = 6'b000101;
   localparam logic [5:0] c_OP_BGTZ  = 6'b000111;
   localparam logic [5:0] c_OP_J     = 6'b000010;
   localparam logic [5:0] c_OP_HALT  = 6'b111110;

   localparam logic [5:0] c_FN_ADD = 6'b100000;
   localparam logic [5:0] c_FN_SUB = 6'b100010;
   localparam logic [5:0] c_FN_AND = 6'b100100;
   localparam logic [5:0] c_FN_OR  = 6'b100101;
   localparam logic [5:0] c_FN_SLL = 6'b000000;
   localparam logic [5:0] c_FN_SLT = 6'b101010;

   localparam logic c_FROM_DATA = 1'b0;
   localparam logic c_FROM_SA   = 1'b1;
   localparam logic c_FROM_IMMD = 1'b1;
   localparam logic c_FROM_ALU  = 1'b0;
   localparam logic c_FROM_DM   = 1'b1;
   localparam logic c_FROM_RT   = 1'b0;
   localparam logic c_FROM_RD   = 1'b1;
   localparam logic c_ZERO_EXD  = 1'b0;
   localparam logic c_SIGN_EXD  = 1'b1;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_SLL  = 3'd2,
      ALU_OR   = 3'd3,
      ALU_AND  = 3'd4,
      ALU_CMPS = 3'd5
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_NEXT = 2'd0,
      PC_REL  = 2'd1,
      PC_ABS  = 2'd2,
      PC_HALT = 2'd3
   } pc_sel_e;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EXE  = 3'd2,
      S_BR   = 3'd3,
      S_MEM  = 3'd4,
      S_WB   = 3'd5,
      S_HALT = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      CL_R    = 3'd0,
      CL_IMM  = 3'd1,
      CL_LW   = 3'd2,
      CL_SW   = 3'd3,
      CL_BR   = 3'd4,
      CL_J    = 3'd5,
      CL_HALT = 3'd6,
      CL_ILL  = 3'd7
   } ins_class_e;

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_op_decode.sv
// ============================================================================
// mc_op_decode : Op/Func -> instruction class, ALU op and datapath mux selects
// Rev 1.0
// ============================================================================
`default_nettype none

import mc_ctrl_pkg::*;

module mc_op_decode (
   input  logic [5:0] i_op,
   input  logic [5:0] i_func,
   output ins_class_e o_class,
   output alu_op_e    o_alu_op,
   output logic       o_alu_src_a,
   output logic       o_alu_src_b,
   output logic       o_ext_sel,
   output logic       o_reg_dst,
   output logic       o_db
);

   always_comb begin
      o_class     = CL_ILL;
      o_alu_op    = ALU_ADD;
      o_alu_src_a = c_FROM_DATA;
      o_alu_src_b = c_FROM_DATA;
      o_ext_sel   = c_SIGN_EXD;
      o_reg_dst   = c_FROM_RD;
      o_db        = c_FROM_ALU;
      case (i_op)
         c_OP_RTYPE: begin
            o_class = CL_R;
            case (i_func)
               c_FN_ADD: o_alu_op = ALU_ADD;
               c_FN_SUB: o_alu_op = ALU_SUB;
               c_FN_AND: o_alu_op = ALU_AND;
               c_FN_OR:  o_alu_op = ALU_OR;
               c_FN_SLT: o_alu_op = ALU_CMPS;
               c_FN_SLL: begin
                  o_alu_op    = ALU_SLL;
                  o_alu_src_a = c_FROM_SA;
               end
               default:  o_class = CL_ILL;
            endcase
         end
         c_OP_ADDI: begin
            o_class     = CL_IMM;
            o_alu_src_b = c_FROM_IMMD;
            o_reg_dst   = c_FROM_RT;
         end
         c_OP_ORI: begin
            o_class     = CL_IMM;
            o_alu_op    = ALU_OR;
            o_alu_src_b = c_FROM_IMMD;
            o_ext_sel   = c_ZERO_EXD;
            o_reg_dst   = c_FROM_RT;
         end
         c_OP_LW: begin
            o_class     = CL_LW;
            o_alu_src_b = c_FROM_IMMD;
            o_reg_dst   = c_FROM_RT;
            o_db        = c_FROM_DM;
         end
         c_OP_SW: begin
            o_class     = CL_SW;
            o_alu_src_b = c_FROM_IMMD;
         end
         c_OP_BEQ, c_OP_BNE, c_OP_BGTZ: begin
            o_class  = CL_BR;
            o_alu_op = ALU_SUB;
         end
         c_OP_J:    o_class = CL_J;
         c_OP_HALT: o_class = CL_HALT;
         default:   o_class = CL_ILL;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ============================================================================
// mc_ctrl : multi-cycle IF/ID/EXE/MEM/WB control FSM with memory wait states
// Rev 1.0
// ============================================================================
`default_nettype none

import mc_ctrl_pkg::*;

module mc_ctrl #(
   parameter int WAIT_MEM = 1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [5:0] i_op,
   input  logic [5:0] i_func,
   input  logic       i_zero,
   input  logic       i_sign,
   input  logic       i_mem_rdy,
   output logic       o_pc_wre,
   output logic       o_ir_wre,
   output logic       o_alu_src_a,
   output logic       o_alu_src_b,
   output logic       o_db,
   output logic       o_reg_wr,
   output logic       o_n_rd,
   output logic       o_n_wr,
   output logic       o_reg_dst,
   output logic       o_ext_sel,
   output logic [1:0] o_pc_sel,
   output logic [2:0] o_alu_op,
   output logic [2:0] o_state,
   output logic       o_illegal_op
);

   state_e     r_state;
   state_e     w_next;
   ins_class_e w_class;
   alu_op_e    w_alu_op;
   pc_sel_e    w_pc_sel;
   logic       w_mem_done;
   logic       w_br_taken;
   logic       w_pc_wre;
   logic       w_ir_wre;
   logic       w_reg_wr;
   logic       w_n_rd;
   logic       w_n_wr;
   logic       w_illegal;

   mc_op_decode u_decode (
      .i_op        (i_op),
      .i_func      (i_func),
      .o_class     (w_class),
      .o_alu_op    (w_alu_op),
      .o_alu_src_a (o_alu_src_a),
      .o_alu_src_b (o_alu_src_b),
      .o_ext_sel   (o_ext_sel),
      .o_reg_dst   (o_reg_dst),
      .o_db        (o_db)
   );

   assign w_mem_done = (WAIT_MEM == 0) || i_mem_rdy;

   always_comb begin
      w_br_taken = 1'b0;
      case (i_op)
         c_OP_BEQ:  w_br_taken = i_zero;
         c_OP_BNE:  w_br_taken = !i_zero;
         c_OP_BGTZ: w_br_taken = !i_zero && !i_sign;
         default:   w_br_taken = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IF;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_pc_wre  = 1'b0;
      w_ir_wre  = 1'b0;
      w_reg_wr  = 1'b0;
      w_n_rd    = 1'b1;
      w_n_wr    = 1'b1;
      w_pc_sel  = PC_NEXT;
      w_illegal = 1'b0;
      case (r_state)
         S_IF: begin
            w_ir_wre = 1'b1;
            w_next   = S_ID;
         end
         S_ID: begin
            case (w_class)
               CL_J: begin
                  w_pc_sel = PC_ABS;
                  w_pc_wre = 1'b1;
                  w_next   = S_IF;
               end
               CL_HALT: w_next = S_HALT;
               CL_BR:   w_next = S_BR;
               CL_ILL: begin
                  w_illegal = 1'b1;
                  w_pc_wre  = 1'b1;
                  w_next    = S_IF;
               end
               default: w_next = S_EXE;
            endcase
         end
         S_EXE: begin
            w_next = (w_class == CL_LW || w_class == CL_SW) ? S_MEM : S_WB;
         end
         S_BR: begin
            w_pc_wre = 1'b1;
            w_pc_sel = w_br_taken ? PC_REL : PC_NEXT;
            w_next   = S_IF;
         end
         S_MEM: begin
            w_n_rd = (w_class != CL_LW);
            w_n_wr = (w_class != CL_SW);
            if (w_mem_done) begin
               if (w_class == CL_SW) begin
                  w_pc_wre = 1'b1;
                  w_next   = S_IF;
               end else begin
                  w_next = S_WB;
               end
            end
         end
         S_WB: begin
            w_reg_wr = 1'b1;
            w_pc_wre = 1'b1;
            w_next   = S_IF;
         end
         S_HALT: begin
            w_pc_sel = PC_HALT;
            w_next   = S_HALT;
         end
         default: w_next = S_IF;
      endcase
      // Reset also silences the strobes combinationally, so nothing leaks while it is held.
      if (!i_rst_n) begin
         w_pc_wre  = 1'b0;
         w_ir_wre  = 1'b0;
         w_reg_wr  = 1'b0;
         w_n_rd    = 1'b1;
         w_n_wr    = 1'b1;
         w_pc_sel  = PC_NEXT;
         w_illegal = 1'b0;
      end
   end

   assign o_pc_wre     = w_pc_wre;
   assign o_ir_wre     = w_ir_wre;
   assign o_reg_wr     = w_reg_wr;
   assign o_n_rd       = w_n_rd;
   assign o_n_wr       = w_n_wr;
   assign o_pc_sel     = w_pc_sel;
   assign o_illegal_op = w_illegal;
   assign o_alu_op     = w_alu_op;
   assign o_state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
// tb_mc_ctrl : randomized instruction stream against a per-instruction cycle model
// Rev 1.0
// ============================================================================
`default_nettype none

import mc_ctrl_pkg::*;

module tb_mc_ctrl;

   localparam int K_R = 0, K_IMM = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_J = 5, K_HALT = 6, K_ILL = 7;

   logic       clk = 1'b0;
   logic       rst0_n = 1'b0, rst1_n = 1'b0;
   logic [5:0] op = 6'd0, func = 6'd0;
   logic       zero = 1'b0, sign = 1'b0, rdy = 1'b0;
   int         sel = 0;
   int         n_total = 0, n_bad = 0;

   logic       pcw0, irw0, sa0, sb0, db0, rw0, nrd0, nwr0, rd0, ext0, ill0;
   logic       pcw1, irw1, sa1, sb1, db1, rw1, nrd1, nwr1, rd1, ext1, ill1;
   logic [1:0] pcs0, pcs1;
   logic [2:0] alu0, alu1, st0, st1;

   mc_ctrl #(.WAIT_MEM(1)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst0_n), .i_op(op), .i_func(func), .i_zero(zero), .i_sign(sign),
      .i_mem_rdy(rdy), .o_pc_wre(pcw0), .o_ir_wre(irw0), .o_alu_src_a(sa0), .o_alu_src_b(sb0),
      .o_db(db0), .o_reg_wr(rw0), .o_n_rd(nrd0), .o_n_wr(nwr0), .o_reg_dst(rd0), .o_ext_sel(ext0),
      .o_pc_sel(pcs0), .o_alu_op(alu0), .o_state(st0), .o_illegal_op(ill0));

   mc_ctrl #(.WAIT_MEM(0)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst1_n), .i_op(op), .i_func(func), .i_zero(zero), .i_sign(sign),
      .i_mem_rdy(rdy), .o_pc_wre(pcw1), .o_ir_wre(irw1), .o_alu_src_a(sa1), .o_alu_src_b(sb1),
      .o_db(db1), .o_reg_wr(rw1), .o_n_rd(nrd1), .o_n_wr(nwr1), .o_reg_dst(rd1), .o_ext_sel(ext1),
      .o_pc_sel(pcs1), .o_alu_op(alu1), .o_state(st1), .o_illegal_op(ill1));

   always #5 clk = ~clk;

   // Strobe bundle {PCWre, IRWre, RegWr, nRD, nWR, IllegalOp, PCSel} and mux bundle of the selected DUT.
   wire [7:0] m_strb = (sel == 1) ? {pcw1, irw1, rw1, nrd1, nwr1, ill1, pcs1}
                                  : {pcw0, irw0, rw0, nrd0, nwr0, ill0, pcs0};
   wire [7:0] m_mux  = (sel == 1) ? {alu1, sa1, sb1, ext1, rd1, db1}
                                  : {alu0, sa0, sb0, ext0, rd0, db0};
   wire [2:0] m_st   = (sel == 1) ? st1 : st0;
   wire [2:0] m_alu  = (sel == 1) ? alu1 : alu0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%02h expected=%02h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] strb(input logic pcw, input logic irw, input logic rw,
                                       input logic nrd, input logic nwr, input logic ill,
                                       input logic [1:0] pcs);
      return {pcw, irw, rw, nrd, nwr, ill, pcs};
   endfunction

   function automatic int kind(input logic [5:0] o, input logic [5:0] f);
      if (o == c_OP_RTYPE)
         return (f inside {c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_SLL, c_FN_SLT}) ? K_R : K_ILL;
      if (o == c_OP_ADDI || o == c_OP_ORI) return K_IMM;
      if (o == c_OP_LW)   return K_LW;
      if (o == c_OP_SW)   return K_SW;
      if (o inside {c_OP_BEQ, c_OP_BNE, c_OP_BGTZ}) return K_BR;
      if (o == c_OP_J)    return K_J;
      if (o == c_OP_HALT) return K_HALT;
      return K_ILL;
   endfunction

   // Expected {ALUop, ALUScrA, ALUScrB, ExtSel, RegDst, DB} straight from the selection rules.
   function automatic logic [7:0] ref_mux(input logic [5:0] o, input logic [5:0] f);
      logic [2:0] a;
      a = 3'(ALU_ADD);
      if (o == c_OP_RTYPE)
         case (f)
            c_FN_SUB: a = 3'(ALU_SUB);
            c_FN_AND: a = 3'(ALU_AND);
            c_FN_OR:  a = 3'(ALU_OR);
            c_FN_SLL: a = 3'(ALU_SLL);
            c_FN_SLT: a = 3'(ALU_CMPS);
            default:  a = 3'(ALU_ADD);
         endcase
      else if (o == c_OP_ORI) a = 3'(ALU_OR);
      return {a,
              (o == c_OP_RTYPE && f == c_FN_SLL),
              (o inside {c_OP_ADDI, c_OP_ORI, c_OP_LW, c_OP_SW}),
              (o != c_OP_ORI),
              !(o inside {c_OP_LW, c_OP_ADDI, c_OP_ORI}),
              (o == c_OP_LW)};
   endfunction

   typedef struct packed {
      logic [2:0] st;
      logic [7:0] sb;
      logic       rdy;
   } cyc_t;

   // Build the cycle-by-cycle expectation for one instruction, then replay it against the DUT.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input logic s, input int waits, input string name);
      cyc_t q[$];
      int   k, nmem, pcw_cnt;
      logic taken, last;
      k = kind(o, f);
      q.push_back('{3'(S_IF), strb(0, 1, 0, 1, 1, 0, 2'(PC_NEXT)), 1'($urandom % 2)});
      if (k == K_J)
         q.push_back('{3'(S_ID), strb(1, 0, 0, 1, 1, 0, 2'(PC_ABS)), 1'($urandom % 2)});
      else if (k == K_ILL)
         q.push_back('{3'(S_ID), strb(1, 0, 0, 1, 1, 1, 2'(PC_NEXT)), 1'($urandom % 2)});
      else
         q.push_back('{3'(S_ID), strb(0, 0, 0, 1, 1, 0, 2'(PC_NEXT)), 1'($urandom % 2)});
      if (k == K_BR) begin
         taken = (o == c_OP_BEQ) ? z : (o == c_OP_BNE) ? !z : (!z && !s);
         q.push_back('{3'(S_BR), strb(1, 0, 0, 1, 1, 0, taken ? 2'(PC_REL) : 2'(PC_NEXT)),
                       1'($urandom % 2)});
      end else if (k == K_R || k == K_IMM || k == K_LW || k == K_SW) begin
         q.push_back('{3'(S_EXE), strb(0, 0, 0, 1, 1, 0, 2'(PC_NEXT)), 1'($urandom % 2)});
         if (k == K_LW || k == K_SW) begin
            nmem = (sel == 1) ? 1 : waits + 1;
            for (int i = 0; i < nmem; i++) begin
               last = (i == nmem - 1);
               q.push_back('{3'(S_MEM),
                             strb(k == K_SW && last, 0, 0, k != K_LW, k != K_SW, 0, 2'(PC_NEXT)),
                             (sel == 1) ? 1'b0 : last});
            end
         end
         if (k != K_SW)
            q.push_back('{3'(S_WB), strb(1, 0, 1, 1, 1, 0, 2'(PC_NEXT)), 1'($urandom % 2)});
      end
      op = o; func = f; zero = z; sign = s;
      pcw_cnt = 0;
      foreach (q[i]) begin
         rdy = q[i].rdy;
         @(negedge clk);
         check($sformatf("%s c%0d state", name, i), {5'd0, m_st}, {5'd0, q[i].st});
         check($sformatf("%s c%0d strobes", name, i), m_strb, q[i].sb);
         if (q[i].st == 3'(S_EXE) || q[i].st == 3'(S_WB))
            check($sformatf("%s c%0d muxes", name, i), m_mux, ref_mux(o, f));
         if (q[i].st == 3'(S_BR))
            check($sformatf("%s c%0d aluop", name, i), {5'd0, m_alu}, {5'd0, 3'(ALU_SUB)});
         pcw_cnt += int'(m_strb[7]);
         @(posedge clk); #1;
      end
      check($sformatf("%s pcwre count", name), 8'(pcw_cnt), 8'd1);
   endtask

   logic [5:0] ops[10] = '{c_OP_RTYPE, c_OP_RTYPE, c_OP_ADDI, c_OP_ORI, c_OP_LW,
                           c_OP_SW, c_OP_BEQ, c_OP_BNE, c_OP_BGTZ, c_OP_J};
   logic [5:0] fns[8]  = '{c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_SLL, c_FN_SLT,
                           6'b111000, 6'b000011};

   task automatic run_random(input int n);
      logic [5:0] o, f;
      for (int i = 0; i < n; i++) begin
         o = ($urandom % 40 == 0) ? 6'b111111 : ops[$urandom % 10];
         f = fns[$urandom % 8];
         run_instr(o, f, 1'($urandom % 2), 1'($urandom % 2), int'($urandom % 3),
                   $sformatf("rnd%0d", i));
      end
   endtask

   initial begin
      sel = 0;
      #3;
      check("reset strobes", m_strb, strb(0, 0, 0, 1, 1, 0, 2'(PC_NEXT)));
      check("reset state", {5'd0, m_st}, {5'd0, 3'(S_IF)});
      @(posedge clk); #1;
      rst0_n = 1'b1;
      #1 check("release irwre", {7'd0, irw0}, 8'd1);

      run_instr(c_OP_RTYPE, c_FN_ADD, 0, 0, 0, "add");
      run_instr(c_OP_LW, 6'd0, 0, 0, 2, "lw_wait2");
      run_instr(c_OP_BEQ, 6'd0, 1, 0, 0, "beq_z1");
      run_instr(c_OP_BNE, 6'd0, 1, 0, 0, "bne_z1");
      run_instr(c_OP_BGTZ, 6'd0, 0, 1, 0, "bgtz_s1");
      run_instr(c_OP_BGTZ, 6'd0, 0, 0, 0, "bgtz_pos");
      run_instr(c_OP_J, 6'd0, 0, 0, 0, "j");
      run_instr(6'b111111, 6'd0, 0, 0, 0, "illegal");
      run_instr(c_OP_SW, 6'd0, 0, 0, 1, "sw_wait1");
      run_instr(c_OP_ORI, 6'd0, 0, 0, 0, "ori");
      run_instr(c_OP_RTYPE, c_FN_SLL, 0, 0, 0, "sll");
      run_random(150);

      // HALT absorbs until reset.
      op = c_OP_HALT; func = 6'd0;
      @(negedge clk);
      check("halt IF", {5'd0, m_st}, {5'd0, 3'(S_IF)});
      @(negedge clk);
      check("halt ID strobes", m_strb, strb(0, 0, 0, 1, 1, 0, 2'(PC_NEXT)));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("halt%0d state", i), {5'd0, m_st}, {5'd0, 3'(S_HALT)});
         check($sformatf("halt%0d strobes", i), m_strb, strb(0, 0, 0, 1, 1, 0, 2'(PC_HALT)));
      end
      rst0_n = 1'b0;
      @(posedge clk); #1;
      rst0_n = 1'b1;
      run_instr(c_OP_RTYPE, c_FN_OR, 0, 0, 0, "after_halt");

      // Reset while an SW is waiting in MEM.
      op = c_OP_SW; func = 6'd0; rdy = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("sw mem state", {5'd0, m_st}, {5'd0, 3'(S_MEM)});
      check("sw mem nwr", {7'd0, nwr0}, 8'd0);
      #2 rst0_n = 1'b0;
      #1;
      check("midrst strobes", m_strb, strb(0, 0, 0, 1, 1, 0, 2'(PC_NEXT)));
      check("midrst state", {5'd0, m_st}, {5'd0, 3'(S_IF)});
      @(posedge clk); #1;
      rst0_n = 1'b1;
      #1 check("midrst release irwre", {7'd0, irw0}, 8'd1);
      run_instr(c_OP_SW, 6'd0, 0, 0, 0, "sw_after_rst");

      // WAIT_MEM=0 instance: MemRdy is ignored, MEM always one cycle.
      rst0_n = 1'b0;
      sel = 1;
      @(posedge clk); #1;
      rst1_n = 1'b1;
      run_instr(c_OP_LW, 6'd0, 0, 0, 2, "nw_lw");
      run_instr(c_OP_SW, 6'd0, 0, 0, 2, "nw_sw");
      run_random(60);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
